// File: rtl/svr_proto_checker.sv
// Per-channel valid/ready protocol checker: stability, drop, stall timeout, transfer counts.
// Optional X/Z detection on the channel signals is enabled with the macro SVR_CHK_X_EN.
module svr_proto_checker #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 4,
  parameter int TIMEOUT    = 256,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            valid,
  input  logic [NUM_CH-1:0]            ready,
  input  logic [NUM_CH*DATA_WIDTH-1:0] data,
  input  logic                         err_clr,
  output logic [NUM_CH-1:0]            err_stable,
  output logic [NUM_CH-1:0]            err_drop,
  output logic [NUM_CH-1:0]            err_timeout,
  output logic [NUM_CH-1:0]            err_x,
  output logic [NUM_CH*CNT_WIDTH-1:0]  xfer_cnt,
  output logic                         any_err
);

  localparam int SW = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, WAIT} st_t;

  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] c);
    if (c >= SW'(TIMEOUT)) return SW'(TIMEOUT);
    return c + 1'b1;
  endfunction

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic [DATA_WIDTH-1:0] d;
    logic                  v, r;
    st_t                   st;
    logic [DATA_WIDTH-1:0] shadow;
    logic [SW-1:0]         stall;
    logic [CNT_WIDTH-1:0]  cnt;
    logic                  stb_p0, drp_p0, tmo_p0;
    logic                  stb_p1, drp_p1, tmo_p1;

    assign d = data[ch*DATA_WIDTH +: DATA_WIDTH];

`ifdef SVR_CHK_X_EN
    logic x_p0, x_p1;

    // Unknown controls count as deasserted so the FSM never follows an X.
    assign v    = (valid[ch] === 1'b1);
    assign r    = (ready[ch] === 1'b1);
    assign x_p0 = $isunknown({valid[ch], ready[ch]}) || (v && r && $isunknown(d));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) x_p1 <= 1'b0;
      else     x_p1 <= (x_p1 & ~err_clr) | x_p0;
    end

    assign err_x[ch] = x_p1;
`else
    assign v         = valid[ch];
    assign r         = ready[ch];
    assign err_x[ch] = 1'b0;
`endif

    // Stage p0: violations detected at this edge
    assign stb_p0 = (st == WAIT) && (d != shadow);
    assign drp_p0 = (st == WAIT) && !v;
    assign tmo_p0 = (st == WAIT) && v && !r && (stall == SW'(TIMEOUT - 1));

    // Stage p1: FSM, counters and sticky flags; a fresh error overrides err_clr
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        st     <= IDLE;
        shadow <= '0;
        stall  <= '0;
        cnt    <= '0;
        stb_p1 <= 1'b0;
        drp_p1 <= 1'b0;
        tmo_p1 <= 1'b0;
      end else begin
        if (v && r) cnt <= cnt + 1'b1;
        case (st)
          IDLE: if (v && !r) begin
            st     <= WAIT;
            shadow <= d;
            stall  <= SW'(1);
          end
          WAIT: if (!v || r) begin
            st    <= IDLE;
            stall <= '0;
          end else begin
            stall <= sat_inc(stall);
          end
          default: st <= IDLE;
        endcase
        stb_p1 <= (stb_p1 & ~err_clr) | stb_p0;
        drp_p1 <= (drp_p1 & ~err_clr) | drp_p0;
        tmo_p1 <= (tmo_p1 & ~err_clr) | tmo_p0;
      end
    end

    assign err_stable[ch]                         = stb_p1;
    assign err_drop[ch]                           = drp_p1;
    assign err_timeout[ch]                        = tmo_p1;
    assign xfer_cnt[ch*CNT_WIDTH +: CNT_WIDTH]    = cnt;
  end

  // Stage p2: summary flag, one cycle behind the sticky flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) any_err <= 1'b0;
    else     any_err <= |{err_stable, err_drop, err_timeout, err_x};
  end

endmodule
